// File: rtl/fm_tx_controller_pkg.sv
// Shared definitions for the FM transmit controller: state encoding and the
// clock-to-sample-rate divider calculation.
`timescale 1ns/1ps
package fm_tx_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_FLUSH  = 2'd3
  } fm_state_e;

  function automatic int unsigned calc_div(input int unsigned fs_clk, input int unsigned fs_in);
    return fs_clk / fs_in;
  endfunction

endpackage

// File: rtl/fm_tx_controller_sample_tick_gen.sv
// Sample-strobe generator: counts 0..DIV-1 while enabled, held at 0 otherwise,
// so the first tick lands DIV cycles after enable rises.
`timescale 1ns/1ps
module sample_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter, wraps on the tick cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (!en) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/fm_tx_controller.sv
// FM modulator sequencer: warm-up, audio pacing with underrun substitution,
// flush and output-strobe watchdog.
`timescale 1ns/1ps
module fm_tx_controller
  import fm_tx_controller_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int FS_CLK      = 4800000,
  parameter int FS_IN       = 48000,
  parameter int FLUSH_TICKS = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int WD_CYCLES   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 mod_rst,
  output logic [WIDTH-1:0]     mod_data,
  output logic                 mod_stb,
  input  logic                 mod_stb_out,
  output logic                 busy,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] underrun_cnt,
  input  logic                 underrun_clr,
  output logic                 wd_err
);

  localparam int DIV = int'(calc_div(FS_CLK, FS_IN));
  localparam int FCW = $clog2(FLUSH_TICKS + 1);
  localparam int WCW = $clog2(WD_CYCLES + 1);

  fm_state_e            state_r;
  logic                 mod_rst_r;
  logic                 mod_stb_r;
  logic [WIDTH-1:0]     mod_data_r;
  logic [CNT_WIDTH-1:0] underrun_cnt_r;
  logic                 wd_err_r;
  logic [FCW-1:0]       zero_cnt_r;
  logic [WCW-1:0]       wd_cnt_r;
  logic                 tick_s;
  logic                 zeros_done_s;
  logic                 wd_hit_s;

  sample_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_r != S_IDLE),
    .tick (tick_s)
  );

  // A zero-sample phase ends the cycle after its last strobe is on the bus
  assign zeros_done_s = mod_stb_r && (zero_cnt_r == FCW'(FLUSH_TICKS));
  assign wd_hit_s     = (state_r == S_RUN) && !mod_stb_out && (wd_cnt_r == WCW'(WD_CYCLES - 1));

  // Sequencer FSM with registered modulator reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      mod_rst_r  <= 1'b1;
      zero_cnt_r <= {FCW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && !stop) begin
            state_r    <= S_WARMUP;
            mod_rst_r  <= 1'b0;
            zero_cnt_r <= {FCW{1'b0}};
          end else begin
            mod_rst_r  <= 1'b1;
          end
        end
        S_WARMUP: begin
          if (stop) begin
            state_r    <= S_FLUSH;
            zero_cnt_r <= {FCW{1'b0}};
          end else if (zeros_done_s) begin
            state_r    <= S_RUN;
            zero_cnt_r <= {FCW{1'b0}};
          end else if (tick_s) begin
            zero_cnt_r <= zero_cnt_r + FCW'(1);
          end
        end
        S_RUN: begin
          if (stop) begin
            state_r    <= S_FLUSH;
            zero_cnt_r <= {FCW{1'b0}};
          end
        end
        S_FLUSH: begin
          if (zeros_done_s) begin
            state_r   <= S_IDLE;
            mod_rst_r <= 1'b1;
          end else if (tick_s) begin
            zero_cnt_r <= zero_cnt_r + FCW'(1);
          end
        end
        default: begin
          state_r   <= S_IDLE;
          mod_rst_r <= 1'b1;
        end
      endcase
    end
  end

  // Sample register: audio only in RUN, silence otherwise or on underrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mod_stb_r  <= 1'b0;
      mod_data_r <= {WIDTH{1'b0}};
    end else begin
      mod_stb_r <= tick_s;
      if (tick_s) begin
        mod_data_r <= ((state_r == S_RUN) && s_valid) ? s_data : {WIDTH{1'b0}};
      end
    end
  end

  // Saturating underrun counter; clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (underrun_clr) begin
      underrun_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if ((state_r == S_RUN) && tick_s && !s_valid &&
                 (underrun_cnt_r != {CNT_WIDTH{1'b1}})) begin
      underrun_cnt_r <= underrun_cnt_r + CNT_WIDTH'(1);
    end
  end

  // Watchdog on modulator output strobe, active only in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r <= {WCW{1'b0}};
      wd_err_r <= 1'b0;
    end else begin
      if ((state_r != S_RUN) || mod_stb_out) begin
        wd_cnt_r <= {WCW{1'b0}};
      end else if (wd_cnt_r != WCW'(WD_CYCLES)) begin
        wd_cnt_r <= wd_cnt_r + WCW'(1);
      end
      if ((state_r == S_IDLE) && start && !stop) begin
        wd_err_r <= 1'b0;
      end else if (wd_hit_s) begin
        wd_err_r <= 1'b1;
      end
    end
  end

  assign s_ready      = (state_r == S_RUN) && tick_s;
  assign mod_rst      = mod_rst_r;
  assign mod_stb      = mod_stb_r;
  assign mod_data     = mod_data_r;
  assign busy         = (state_r != S_IDLE);
  assign state        = state_r;
  assign underrun_cnt = underrun_cnt_r;
  assign wd_err       = wd_err_r;

endmodule

// File: tb/tb_fm_tx_controller.sv
// Self-checking bench: cycle-level reference model plus directed scenarios
// and a randomized phase; a CNT_WIDTH=4 twin covers counter saturation.
`timescale 1ns/1ps
module tb_fm_tx_controller;

  localparam int DIVV = 100;
  localparam int FT   = 8;
  localparam int WD   = 256;

  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, s_valid = 1'b0;
  logic        mod_stb_out = 1'b0, underrun_clr = 1'b0;
  logic [15:0] s_data = 16'd0;
  logic        wd_tie = 1'b0;
  logic        rand_stb = 1'b0;

  logic        s_ready, mod_rst, mod_stb, busy, wd_err;
  logic [15:0] mod_data, underrun_cnt;
  logic [1:0]  state;
  logic        s_ready4, mod_rst4, mod_stb4, busy4, wd_err4;
  logic [15:0] mod_data4;
  logic [3:0]  underrun_cnt4;
  logic [1:0]  state4;

  int    checks = 0, failures = 0;
  longint cyc = 0;

  fm_tx_controller #(.WIDTH(16), .FS_CLK(4800000), .FS_IN(48000), .FLUSH_TICKS(FT),
                     .CNT_WIDTH(16), .WD_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .mod_rst(mod_rst), .mod_data(mod_data), .mod_stb(mod_stb),
    .mod_stb_out(mod_stb_out), .busy(busy), .state(state), .underrun_cnt(underrun_cnt),
    .underrun_clr(underrun_clr), .wd_err(wd_err));

  fm_tx_controller #(.WIDTH(16), .FS_CLK(4800000), .FS_IN(48000), .FLUSH_TICKS(FT),
                     .CNT_WIDTH(4), .WD_CYCLES(WD)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready4), .mod_rst(mod_rst4), .mod_data(mod_data4), .mod_stb(mod_stb4),
    .mod_stb_out(mod_stb_out), .busy(busy4), .state(state4), .underrun_cnt(underrun_cnt4),
    .underrun_clr(underrun_clr), .wd_err(wd_err4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic longint sat(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  // Reference model: mode (0..3), cycles since leaving idle, zero strobes in phase
  int          m_mode = 0, m_elapsed = 0, m_zeros = 0, m_wdc = 0;
  longint      m_und = 0;
  logic        m_stb = 1'b0, m_wd_err = 1'b0;
  logic [15:0] m_data = 16'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_mode = 0; m_elapsed = 0; m_zeros = 0; m_wdc = 0; m_und = 0;
        m_stb = 1'b0; m_wd_err = 1'b0; m_data = 16'd0;
      end
      begin
        bit tick, done;
        int nm;
        tick = (m_mode != 0) && ((m_elapsed % DIVV) == DIVV - 1);
        check("state", state, m_mode);
        check("mod_rst", mod_rst, m_mode == 0);
        check("busy", busy, m_mode != 0);
        check("mod_stb", mod_stb, m_stb);
        check("mod_data", mod_data, m_data);
        check("s_ready", s_ready, (m_mode == 2) && tick);
        check("wd_err", wd_err, m_wd_err);
        check("underrun_cnt", underrun_cnt, sat(m_und, 65535));
        check("underrun_cnt_w4", underrun_cnt4, sat(m_und, 15));
        if (!rst) begin
          done = m_stb && (m_zeros == FT);
          nm = m_mode;
          if (underrun_clr) m_und = 0;
          else if (m_mode == 2 && tick && !s_valid) m_und++;
          if (m_mode == 2 && !mod_stb_out) begin
            m_wdc++;
            if (m_wdc == WD) m_wd_err = 1'b1;
          end else begin
            m_wdc = 0;
          end
          case (m_mode)
            0: if (start && !stop) begin nm = 1; m_zeros = 0; m_wd_err = 1'b0; end
            1: if (stop) begin nm = 3; m_zeros = 0; end
               else if (done) begin nm = 2; m_zeros = 0; end
               else if (tick) m_zeros++;
            2: if (stop) begin nm = 3; m_zeros = 0; end
            default: if (done) nm = 0; else if (tick) m_zeros++;
          endcase
          if (tick) m_data = (m_mode == 2 && s_valid) ? s_data : 16'd0;
          m_stb = tick;
          if (nm == 0 || m_mode == 0) m_elapsed = 0; else m_elapsed++;
          m_mode = nm;
        end
      end
    end
  end

  // Modulator output strobe: periodic keepalive unless tied low
  initial begin
    forever begin
      @(posedge clk); #1;
      mod_stb_out = !wd_tie && (((cyc % 64) == 0) || rand_stb);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input bit do_start, input bit do_stop);
    start = do_start; stop = do_stop;
    step();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_state(input string name, input int st, input int budget);
    int n = 0;
    while (state !== 2'(st) && n < budget) begin step(); n++; end
    check(name, state, st);
  endtask

  task automatic wait_stb(input string name, input int budget, output int n);
    n = 0;
    do begin step(); n++; end while (mod_stb !== 1'b1 && n < budget);
    check(name, mod_stb, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int n, rc;
    longint t0;
    repeat (3) step();
    check("rst_state", state, 0);
    check("rst_mod_rst", mod_rst, 1);
    check("rst_mod_stb", mod_stb, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // 1: warm-up timing
    start = 1'b1; t0 = cyc;
    step();
    start = 1'b0;
    check("t1_mod_rst_drop", mod_rst, 0);
    check("t1_state_warmup", state, 1);
    wait_stb("t1_stb0", 200, n);
    check("t1_first_stb_cycle", cyc - t0, 101);
    for (int i = 1; i < FT; i++) begin
      wait_stb("t1_stb", 200, n);
      check("t1_stb_spacing", n, 100);
      check("t1_zero_data", mod_data, 0);
    end
    step();
    check("t1_state_run", state, 2);

    // 2: ramp
    s_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_data = 16'(i);
      wait_stb("t2_stb", 200, n);
      check("t2_ramp", mod_data, i);
    end
    check("t2_underrun", underrun_cnt, 0);
    rc = 0;
    for (int i = 0; i < 200; i++) begin step(); rc += int'(s_ready); end
    check("t2_ready_rate", rc, 2);

    // 3: underrun and clear
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_stb("t3_stb", 200, n);
      check("t3_silence", mod_data, 0);
    end
    check("t3_underrun5", underrun_cnt, 5);
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin step(); n++; end
    check("t3_find_tick", s_ready, 1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("t3_clr_wins", underrun_cnt, 0);

    // saturation of the 4-bit twin
    for (int i = 0; i < 19; i++) wait_stb("sat_stb", 200, n);
    check("sat_w16", underrun_cnt, 19);
    check("sat_w4", underrun_cnt4, 15);
    s_valid = 1'b1;

    // 4: stop and flush
    step();
    pulse(1'b0, 1'b1);
    rc = 0; n = 0;
    while (state !== 2'd0 && n < 1200) begin
      if (mod_stb === 1'b1) begin rc++; check("t4_flush_zero", mod_data, 0); end
      step(); n++;
    end
    check("t4_idle", state, 0);
    check("t4_flush_count", rc, FT);
    check("t4_mod_rst", mod_rst, 1);
    pulse(1'b1, 1'b1);
    check("t4_start_stop_idle", state, 0);

    // 5: watchdog
    wd_tie = 1'b1;
    pulse(1'b1, 1'b0);
    wait_state("t5_run", 2, 1200);
    n = 0;
    while (wd_err !== 1'b1 && n < 400) begin step(); n++; end
    check("t5_wd_latency", n, 256);
    repeat (100) step();
    check("t5_wd_sticky", wd_err, 1);
    check("t5_no_state_change", state, 2);
    pulse(1'b0, 1'b1);
    wait_state("t5_idle", 0, 1200);
    check("t5_wd_kept_idle", wd_err, 1);
    wd_tie = 1'b0;
    pulse(1'b1, 1'b0);
    check("t5_wd_cleared", wd_err, 0);

    // randomized phase
    for (int i = 0; i < 15000; i++) begin
      start        = ($urandom_range(0, 199) == 0);
      stop         = ($urandom_range(0, 399) == 0);
      s_valid      = ($urandom_range(0, 3) != 0);
      s_data       = 16'($urandom);
      underrun_clr = ($urandom_range(0, 299) == 0);
      rand_stb     = ($urandom_range(0, 39) == 0);
      wd_tie       = (i >= 6000 && i < 9000);
      step();
    end
    start = 1'b0; stop = 1'b0; underrun_clr = 1'b0; rand_stb = 1'b0; wd_tie = 1'b0;

    // 6: async reset mid-flush
    pulse(1'b0, 1'b1);
    wait_state("t6_idle", 0, 2000);
    pulse(1'b1, 1'b0);
    wait_state("t6_run", 2, 1200);
    s_valid = 1'b0;
    wait_stb("t6_stb", 200, n);
    wait_stb("t6_stb", 200, n);
    check("t6_underrun_nonzero", underrun_cnt != 16'd0, 1);
    pulse(1'b0, 1'b1);
    repeat (150) step();
    check("t6_in_flush", state, 3);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("t6_state", state, 0);
    check("t6_mod_rst", mod_rst, 1);
    check("t6_mod_stb", mod_stb, 0);
    check("t6_mod_data", mod_data, 0);
    check("t6_s_ready", s_ready, 0);
    check("t6_busy", busy, 0);
    check("t6_underrun", underrun_cnt, 0);
    check("t6_wd_err", wd_err, 0);
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    check("t6_stays_idle", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
